digit_entry: RTL
================

DIGIT_ENTRY -- requirements
Module: digit_entry

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 4, number of clock cycles loadn must stay low before a digit is accepted (legal range 1..255).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 D  input  4  digit code from the keypad encoder; valid while loadn is low.
REQ-005 loadn  input  1  active-low key-present strobe from the keypad encoder; asynchronous to clk.
REQ-006 lockn  input  1  active-low entry enable; digits are accepted only while low (the controller drives it high during cooking).
REQ-007 clearn  input  1  synchronous active-low clear of the entered time.
REQ-008 sec_ones  output  4  BCD seconds-units digit.
REQ-009 sec_tens  output  4  BCD seconds-tens digit.
REQ-010 minutes  output  4  BCD minutes digit.
REQ-011 digit_strobe  output  1  one-cycle pulse marking a newly accepted digit.
REQ-012 nonzero  output  1  high when any stored digit is nonzero.

Function
REQ-013 loadn and D SHALL each pass through a 2-flop synchronizer (loadn_s, D_s) before use; no other logic samples the raw inputs.
REQ-014 FSM states SHALL be IDLE, DEBOUNCE and WAIT_RELEASE, with an 8-bit debounce counter cnt.
REQ-015 IDLE -> DEBOUNCE (cnt=0) when loadn_s=0 and lockn=0; otherwise remain in IDLE.
REQ-016 In DEBOUNCE, loadn_s=1 or lockn=1 SHALL return the FSM to IDLE with no digit accepted.
REQ-017 In DEBOUNCE with loadn_s=0, cnt SHALL increment; the edge where cnt==DEBOUNCE_CYCLES-1 SHALL accept the digit and move the FSM to WAIT_RELEASE.
REQ-018 Accept: minutes<=sec_tens, sec_tens<=sec_ones, sec_ones<=D_s, and digit_strobe=1 for exactly the following cycle; the old minutes value is discarded.
REQ-019 Accept SHALL be suppressed when D_s>9: the FSM still moves to WAIT_RELEASE, with no shift and no strobe.
REQ-020 WAIT_RELEASE -> IDLE when loadn_s=1, so a held key yields exactly one digit.
REQ-021 Latency: with loadn low and D stable before edge E0, digit_strobe SHALL be high in the cycle after edge E0+2+DEBOUNCE_CYCLES (default E0+6).
REQ-022 sec_tens SHALL store the value as entered (6..9 allowed); normalisation belongs to the downstream timer.
REQ-023 clearn=0 SHALL zero all three digits on that edge and suppress any accept on the same edge.
  - Next state is WAIT_RELEASE if loadn_s=0, otherwise IDLE.
REQ-024 nonzero SHALL be combinational from the three digit registers.

Reset
REQ-025 While resetn=0: digits=0, digit_strobe=0, FSM=IDLE, cnt=0, and all synchronizer flops=1 (loadn idle, D=4'hF).
REQ-026 Deassertion of resetn SHALL produce no strobe even if loadn is already low; the key counts only after it passes through the synchronizer and DEBOUNCE.
REQ-027 Reset mid-DEBOUNCE SHALL abort the pending digit.

Verification
REQ-028 After reset, press D=1, then 3, then 0 (each held low 10 cycles, released 10 cycles) -> minutes=1, sec_tens=3, sec_ones=0, three strobes, nonzero=1.
REQ-029 Hold loadn low with D=7 for 50 cycles -> exactly one strobe, in the cycle after edge E0+6; sec_ones=7.
REQ-030 Glitch loadn low for 2 cycles (DEBOUNCE_CYCLES=4) -> no strobe, digits unchanged.
REQ-031 Enter 1,2,3,4 -> minutes=2, sec_tens=3, sec_ones=4; digit 1 is discarded.
REQ-032 lockn=1 during a press of 5 -> no strobe; then clearn pulse -> all digits 0, nonzero=0.
REQ-033 D=4'hA pressed -> no strobe, no shift; FSM returns to IDLE after release.

Source files
------------

// File: rtl/digit_entry.sv
// Keypad digit capture: synchronizes loadn/D, debounces, shifts BCD digits left on accept.
// Latency: strobe in the cycle after edge E0+2+DEBOUNCE_CYCLES; no backpressure, one digit per held key.
module digit_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       lockn,
  input  logic       clearn,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] minutes,
  output logic       digit_strobe,
  output logic       nonzero
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] DEBOUNCE     = 2'd1;
  localparam logic [1:0] WAIT_RELEASE = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       loadn_m, loadn_s;
  logic [3:0] d_m, d_s;
  logic [1:0] state;
  logic [7:0] cnt;

  // Synchronizers reset to the idle key code so a key held through reset is seen as a fresh press.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      loadn_m <= 1'b1;
      loadn_s <= 1'b1;
      d_m     <= 4'hF;
      d_s     <= 4'hF;
    end else begin
      loadn_m <= loadn;
      loadn_s <= loadn_m;
      d_m     <= D;
      d_s     <= d_m;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      sec_ones     <= 4'd0;
      sec_tens     <= 4'd0;
      minutes      <= 4'd0;
      digit_strobe <= 1'b0;
    end else begin
      digit_strobe <= 1'b0;
      if (!clearn) begin
        sec_ones <= 4'd0;
        sec_tens <= 4'd0;
        minutes  <= 4'd0;
        cnt      <= 8'd0;
        // A key still held during clear must be released before it can count.
        state    <= loadn_s ? IDLE : WAIT_RELEASE;
      end else begin
        case (state)
          IDLE: begin
            if (!loadn_s && !lockn) begin
              state <= DEBOUNCE;
              cnt   <= 8'd0;
            end
          end
          DEBOUNCE: begin
            if (loadn_s || lockn) begin
              state <= IDLE;
              cnt   <= 8'd0;
            end else if (cnt == CNT_LAST) begin
              state <= WAIT_RELEASE;
              cnt   <= 8'd0;
              if (d_s <= 4'd9) begin
                minutes      <= sec_tens;
                sec_tens     <= sec_ones;
                sec_ones     <= d_s;
                digit_strobe <= 1'b1;
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          WAIT_RELEASE: begin
            if (loadn_s) state <= IDLE;
          end
          default: begin
            state <= IDLE;
            cnt   <= 8'd0;
          end
        endcase
      end
    end
  end

  assign nonzero = |{minutes, sec_tens, sec_ones};

endmodule
